nla_poly_seq_ctrl: RTL and testbench

//  Parametrised sequencer for the non-linear approximation engine. Evaluates a runtime-degree polynomial by Horner's method.
//  Per channel: fills the signal and coefficient buffers, then issues one MAC step per coefficient.

---
 rtl/nla_poly_seq_ctrl_pkg.sv | 18 +
 rtl/nla_poly_seq_ctrl_if.sv | 35 +++
 rtl/nla_poly_seq_ctrl_lat_timer.sv | 31 +++
 rtl/nla_poly_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_nla_poly_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nla_poly_seq_ctrl_pkg.sv
// Shared types for the polynomial sequencer: FSM state encoding and width helpers.
package nla_poly_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PRIME = 3'd2,
        ST_STEP  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_OUT   = 3'd5
    } state_e;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nla_poly_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer (master) and buffers, MAC and result sink (slave).
interface nla_poly_seq_ctrl_if #(
    parameter int ADDR_LINES = 4,
    parameter int CH_W       = 1
);
    logic                  start_i;
    logic                  abort_i;
    logic [ADDR_LINES-1:0] degree_i;
    logic                  sig_full_i;
    logic                  coeff_full_i;
    logic                  wr_en_signal_o;
    logic                  wr_en_coeff_o;
    logic                  rd_en_signal_o;
    logic                  rd_en_coeff_o;
    logic [ADDR_LINES-1:0] coeff_addr_o;
    logic                  acc_init_o;
    logic                  mac_en_o;
    logic [CH_W-1:0]       ch_sel_o;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        input  start_i, abort_i, degree_i, sig_full_i, coeff_full_i, res_ready_i,
        output wr_en_signal_o, wr_en_coeff_o, rd_en_signal_o, rd_en_coeff_o,
               coeff_addr_o, acc_init_o, mac_en_o, ch_sel_o, res_valid_o, busy_o, done_o
    );

    modport slave (
        output start_i, abort_i, degree_i, sig_full_i, coeff_full_i, res_ready_i,
        input  wr_en_signal_o, wr_en_coeff_o, rd_en_signal_o, rd_en_coeff_o,
               coeff_addr_o, acc_init_o, mac_en_o, ch_sel_o, res_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/nla_poly_seq_ctrl_lat_timer.sv
// MAC latency timer: clear, count up while enabled, flag the last wait cycle.
module nla_lat_timer #(
    parameter int MAC_LAT = 12
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int LW = $clog2(MAC_LAT + 1);

    logic [LW-1:0] lat_q, lat_d;

    always_comb begin
        lat_d = lat_q;
        if (clr_i)
            lat_d = '0;
        else if (en_i)
            lat_d = lat_q + LW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            lat_q <= '0;
        else
            lat_q <= lat_d;
    end

    assign expire_o = (lat_q == LW'(MAC_LAT - 1));
endmodule

// File: rtl/nla_poly_seq_ctrl.sv
// Horner-method sequencer: loads buffers per channel, issues one MAC per coefficient,
// spaces MACs by the datapath latency and hands each channel's result downstream.
module nla_poly_seq_ctrl
    import nla_poly_seq_ctrl_pkg::*;
#(
    parameter int ADDR_LINES = 4,
    parameter int NUM_CH     = 1,
    parameter int MAC_LAT    = 12
) (
    input logic                 clk_i,
    input logic                 rstn_i,
    nla_poly_seq_ctrl_if.master bus
);
    localparam int CH_W = min1_clog2(NUM_CH);

    state_e                state_q, state_d;
    logic [ADDR_LINES-1:0] deg_q, deg_d;
    logic [ADDR_LINES-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic                  done_q, done_d;
    logic                  lat_clr, lat_en, lat_exp;
    logic                  both_full, last_ch;

    assign both_full = bus.sig_full_i & bus.coeff_full_i;
    assign last_ch   = (ch_q == CH_W'(NUM_CH - 1));

    nla_lat_timer #(.MAC_LAT(MAC_LAT)) u_lat (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clr_i    (lat_clr),
        .en_i     (lat_en),
        .expire_o (lat_exp)
    );

    always_comb begin
        state_d = state_q;
        deg_d   = deg_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        done_d  = 1'b0;
        lat_clr = 1'b0;
        lat_en  = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start_i) begin
                deg_d   = bus.degree_i;
                ch_d    = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: if (both_full) begin
                cnt_d   = deg_q;
                state_d = ST_PRIME;
            end
            ST_PRIME: state_d = ST_STEP;
            ST_STEP: begin
                if (cnt_q == '0) begin
                    state_d = ST_OUT;
                end else begin
                    cnt_d   = cnt_q - ADDR_LINES'(1);
                    lat_clr = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                lat_en = 1'b1;
                if (lat_exp)
                    state_d = ST_STEP;
            end
            ST_OUT: if (bus.res_ready_i) begin
                if (last_ch) begin
                    done_d  = 1'b1;
                    ch_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    // Coefficients are shared, so the next channel only refills its signal bank.
                    ch_d    = ch_q + CH_W'(1);
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.abort_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            deg_d   = '0;
            cnt_d   = '0;
            ch_d    = '0;
            done_d  = 1'b0;
            lat_clr = 1'b1;
            lat_en  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            deg_q   <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            deg_q   <= deg_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
        end
    end

    // Only the LOAD strobes look at inputs; everything else decodes from registered state.
    always_comb begin
        bus.wr_en_signal_o = 1'b0;
        bus.wr_en_coeff_o  = 1'b0;
        bus.rd_en_signal_o = 1'b0;
        bus.rd_en_coeff_o  = 1'b0;
        bus.acc_init_o     = 1'b0;
        bus.mac_en_o       = 1'b0;
        bus.coeff_addr_o   = '0;
        bus.res_valid_o    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (!bus.sig_full_i) begin
                    bus.wr_en_signal_o = 1'b1;
                end else if (!bus.coeff_full_i) begin
                    bus.wr_en_coeff_o = 1'b1;
                end else begin
                    bus.rd_en_signal_o = 1'b1;
                    bus.rd_en_coeff_o  = 1'b1;
                    bus.acc_init_o     = 1'b1;
                    bus.coeff_addr_o   = deg_q;
                end
            end
            ST_STEP: if (cnt_q != '0) begin
                bus.rd_en_coeff_o = 1'b1;
                bus.mac_en_o      = 1'b1;
                bus.coeff_addr_o  = cnt_q - ADDR_LINES'(1);
            end
            ST_OUT:  bus.res_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy_o   = (state_q != ST_IDLE);
    assign bus.done_o   = done_q;
    assign bus.ch_sel_o = ch_q;
endmodule

// File: tb/tb_nla_poly_seq_ctrl.sv
// Bench for nla_poly_seq_ctrl: schedule-based reference model checked every cycle,
// a bench-side Horner datapath driven by the strobes, and directed scenario checks.
module tb_nla_poly_seq_ctrl;
    localparam int AL = 4, NCH = 4, LAT = 12, CW = 2;
    localparam int B_BUSY = 14, B_DONE = 13, B_VAL = 12, B_WS = 9, B_WC = 8;
    localparam int B_RS = 7, B_RC = 6, B_INIT = 5, B_MAC = 4;
    localparam int P_IDLE = 0, P_LOAD = 1, P_CALC = 2, P_OUT = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nla_poly_seq_ctrl_if #(.ADDR_LINES(AL), .CH_W(CW)) bus ();
    nla_poly_seq_ctrl #(.ADDR_LINES(AL), .NUM_CH(NCH), .MAC_LAT(LAT)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int chk = 0, err = 0, cyc = 0;
    // reference model state: phase, cycles since LOAD exit, latched degree, channel
    int ph = P_IDLE, t = 0, md = 0, mch = 0;
    bit done_f = 1'b0;
    int sig_wr = 0, coeff_wr = 0, sig_need = 0, coeff_need = 0;
    longint c[16] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3, 5, 8, 9, 7, 9, 3};
    longint x[4]  = '{2, 3, 1, 5};
    longint acc = 0;
    logic [14:0] o_neg = '0;
    int init_cyc, init_addr, first_mac_cyc, valid_cyc, hs_cnt, done_cnt, hs_cyc, done_cyc;
    int wr_s_cnt, wr_c_cnt, wr_c_late, cur_vlen;
    bit mac_since_init, prev_valid;
    int mac_q[$], hs_ch[$], vlen_q[$];

    function automatic logic [14:0] dut_vec();
        return {bus.busy_o, bus.done_o, bus.res_valid_o, bus.ch_sel_o, bus.wr_en_signal_o,
                bus.wr_en_coeff_o, bus.rd_en_signal_o, bus.rd_en_coeff_o, bus.acc_init_o,
                bus.mac_en_o, bus.coeff_addr_o};
    endfunction

    // MAC k (k=0..D-1) lands at LOAD-exit + 2 + k*(LAT+1); result is valid at +3 + D*(LAT+1).
    function automatic logic [14:0] model_vec();
        logic [14:0] e = '0;
        int u;
        e[B_BUSY]  = (ph != P_IDLE);
        e[B_DONE]  = done_f;
        e[11:10]   = 2'(mch);
        case (ph)
            P_LOAD: begin
                if (!bus.sig_full_i) e[B_WS] = 1'b1;
                else if (!bus.coeff_full_i) e[B_WC] = 1'b1;
                else begin
                    e[B_RS] = 1'b1; e[B_RC] = 1'b1; e[B_INIT] = 1'b1; e[3:0] = 4'(md);
                end
            end
            P_CALC: if (t >= 2) begin
                u = t - 2;
                if (u < md * (LAT + 1) && u % (LAT + 1) == 0) begin
                    e[B_RC] = 1'b1; e[B_MAC] = 1'b1; e[3:0] = 4'(md - 1 - u / (LAT + 1));
                end
            end
            P_OUT: e[B_VAL] = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic longint poly(input int d, input longint xv);
        longint s = 0, pw = 1;
        for (int i = 0; i <= d; i++) begin
            s += c[i] * pw;
            pw *= xv;
        end
        return s;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        chk++;
        if (got !== want) begin
            err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic clear_stats();
        init_cyc = 0; init_addr = -1; first_mac_cyc = 0; valid_cyc = 0; hs_cnt = 0;
        done_cnt = 0; hs_cyc = 0; done_cyc = 0; wr_s_cnt = 0; wr_c_cnt = 0; wr_c_late = 0;
        cur_vlen = 0; mac_since_init = 1'b0;
        mac_q.delete(); hs_ch.delete(); vlen_q.delete();
    endtask

    // One clock: bench buffers/datapath and model advance at the edge, outputs compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            ph = P_IDLE; mch = 0; done_f = 1'b0;
        end else begin
            if (o_neg[B_WS]) begin sig_wr++; wr_s_cnt++; end
            if (o_neg[B_WC]) begin
                coeff_wr++; wr_c_cnt++;
                if (o_neg[11:10] != 2'd0) wr_c_late++;
            end
            if (o_neg[B_INIT]) begin
                acc = c[o_neg[3:0]]; init_cyc = cyc; init_addr = int'(o_neg[3:0]);
                mac_since_init = 1'b0;
            end
            if (o_neg[B_MAC]) begin
                acc = acc * x[o_neg[11:10]] + c[o_neg[3:0]];
                mac_q.push_back(int'(o_neg[3:0]));
                if (!mac_since_init) first_mac_cyc = cyc;
                mac_since_init = 1'b1;
            end
            if (o_neg[B_VAL] && !prev_valid) valid_cyc = cyc;
            if (o_neg[B_VAL]) cur_vlen++;
            if (o_neg[B_VAL] && bus.res_ready_i && !bus.abort_i) begin
                check("horner_result", acc, poly(md, x[o_neg[11:10]]));
                hs_cnt++; hs_cyc = cyc; hs_ch.push_back(int'(o_neg[11:10]));
                vlen_q.push_back(cur_vlen); cur_vlen = 0;
                sig_wr = 0;
            end
            if (o_neg[B_DONE]) begin done_cnt++; done_cyc = cyc; end

            done_f = 1'b0;
            if (bus.abort_i && ph != P_IDLE) begin
                ph = P_IDLE; mch = 0;
            end else begin
                case (ph)
                    P_IDLE: if (bus.start_i) begin md = int'(bus.degree_i); mch = 0; ph = P_LOAD; end
                    P_LOAD: if (bus.sig_full_i && bus.coeff_full_i) begin ph = P_CALC; t = 1; end
                    P_CALC: begin
                        t++;
                        if (t == 3 + md * (LAT + 1)) ph = P_OUT;
                    end
                    P_OUT: if (bus.res_ready_i) begin
                        if (mch == NCH - 1) begin done_f = 1'b1; ph = P_IDLE; mch = 0; end
                        else begin mch++; ph = P_LOAD; end
                    end
                    default: ph = P_IDLE;
                endcase
            end
        end
        prev_valid = o_neg[B_VAL];
        #2;
        bus.sig_full_i   = (sig_wr >= sig_need);
        bus.coeff_full_i = (coeff_wr >= coeff_need);
        @(negedge clk);
        o_neg = dut_vec();
        check("cycle_outputs", longint'(o_neg), longint'(model_vec()));
    endtask

    task automatic start_job(input int d, input int sneed, input int cneed);
        clear_stats();
        sig_need = sneed; coeff_need = cneed; sig_wr = 0; coeff_wr = 0;
        bus.degree_i = 4'(d);
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin tick(); n++; end
        if (done_cnt == 0) check({name, "_timeout"}, 0, 1);
        repeat (2) tick();
    endtask

    initial begin
        int n;
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.degree_i = '0;
        bus.sig_full_i = 1'b0; bus.coeff_full_i = 1'b0; bus.res_ready_i = 1'b1;
        clear_stats();
        repeat (3) tick();
        check("reset_outputs", longint'(o_neg), 0);
        rstn = 1'b1;
        tick();

        // D=3, coefficients preloaded, two signal writes per channel, ready tied high
        start_job(3, 2, 0);
        run_until_done(1000, "d3");
        check("d3_init_addr", init_addr, 3);
        check("d3_mac_addr0", mac_q[0], 2);
        check("d3_mac_addr1", mac_q[1], 1);
        check("d3_mac_addr2", mac_q[2], 0);
        check("d3_mac_count", mac_q.size(), 12);
        check("d3_step_to_valid", valid_cyc - first_mac_cyc, 40);
        check("d3_handshakes", hs_cnt, 4);
        check("d3_done_count", done_cnt, 1);
        check("d3_done_after_hs", done_cyc - hs_cyc, 1);
        check("d3_ch_order1", hs_ch[1], 1);
        check("d3_ch_order3", hs_ch[3], 3);

        // D=0, everything empty at start
        start_job(0, 3, 2);
        run_until_done(500, "d0");
        check("d0_init_to_valid", valid_cyc - init_cyc, 3);
        check("d0_mac_count", mac_q.size(), 0);
        check("d0_sig_writes", wr_s_cnt, 12);
        check("d0_coeff_writes", wr_c_cnt, 2);
        check("d0_coeff_late", wr_c_late, 0);
        check("d0_handshakes", hs_cnt, 4);

        // back-pressure: ready low for the first five OUT cycles of ch0
        bus.res_ready_i = 1'b0;
        start_job(1, 1, 0);
        n = 0;
        while (!o_neg[B_VAL] && n < 200) begin tick(); n++; end
        check("hold_reach_out", o_neg[B_VAL], 1);
        repeat (5) tick();
        bus.res_ready_i = 1'b1;
        run_until_done(500, "hold");
        check("hold_valid_len_ch0", vlen_q[0], 6);
        check("hold_valid_len_ch1", vlen_q[1], 1);
        check("hold_handshakes", hs_cnt, 4);

        // abort during WAIT
        start_job(5, 0, 0);
        n = 0;
        while (mac_q.size() < 1 && n < 100) begin tick(); n++; end
        repeat (3) tick();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        check("abort_outputs", longint'(o_neg), 0);
        repeat (3) tick();
        check("abort_mac_count", mac_q.size(), 1);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_hs", hs_cnt, 0);

        // start and degree change while busy are ignored
        start_job(2, 1, 1);
        repeat (10) tick();
        bus.degree_i = 4'd7;
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        run_until_done(1000, "busy_start");
        check("busy_mac_count", mac_q.size(), 8);
        check("busy_handshakes", hs_cnt, 4);
        check("busy_done_count", done_cnt, 1);

        // reset asserted in the second STEP, then a clean job
        start_job(4, 0, 0);
        n = 0;
        while (!(o_neg[B_MAC] && mac_q.size() == 1) && n < 100) begin tick(); n++; end
        check("rst_in_step", o_neg[B_MAC], 1);
        rstn = 1'b0;
        tick();
        check("rst_outputs", longint'(o_neg), 0);
        rstn = 1'b1;
        tick();
        start_job(2, 2, 1);
        run_until_done(1000, "post_rst");
        check("post_rst_handshakes", hs_cnt, 4);
        check("post_rst_done_count", done_cnt, 1);
        check("post_rst_mac_count", mac_q.size(), 8);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
